mwb_stage: RTL and testbench
============================

Name: mwb_stage

Overview:
- Memory/writeback stage of the three-stage RISC-V pipeline.
- Consumes the EX→MWB pipeline register outputs.
- Performs data-memory loads and stores over a req/gnt/rvalid bus, aligns and sign-extends load data, selects the writeback source, and drives the register-file write port.
- Asserts a stall to hold upstream stages while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles from grant to rvalid before the access is aborted with a bus error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instruction_in  in  32  instruction; rd = [11:7], store funct3 = [14:12].
- ALU_result_in  in  32  ALU result; the memory byte address for loads and stores.
- IMME_result_in  in  32  immediate (LUI path).
- PC_in  in  32  instruction PC.
- rs2_data_in  in  32  store data.
- Reg_WE_in  in  1  register write enable.
- DMEM_sel_in  in  2  memory op: 00 none, 01 load, 10 store, 11 treated as none.
- LOAD_sel_in  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others treated as LW.
- WB_sel_in  in  2  writeback source: 00 ALU, 01 load data, 10 PC+4, 11 IMME.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word address {ALU_result_in[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  store data shifted into lane position.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  response valid (load data or store ack).
- dmem_rdata  in  32  load word.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  destination register.
- rf_wdata  out  32  writeback data.
- mwb_stall  out  1  hold EX→MWB register and upstream stages.
- misalign_err  out  1  one-cycle pulse: misaligned access.
- bus_err  out  1  one-cycle pulse: response timeout.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; timeout counter 0; load-data register 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, DMEM_sel none:
  - Combinational writeback this cycle; mwb_stall=0.
  - rf_we = Reg_WE_in & (rd≠0).
  - WB_sel 10 gives PC_in+4, mod 2^32.
- IDLE, memory op:
  - Misaligned cases: halfword with addr[0]=1, or word with addr[1:0]≠0. Result: misalign_err pulses, no request, rf_we=0, no stall, stay IDLE.
  - Otherwise: mwb_stall=1 and dmem_req=1 in the same cycle. If dmem_gnt is also high, go to WAIT; else go to REQ.
- REQ: dmem_req held with stable addr/be/wdata/we until gnt, then go to WAIT. No timeout applies here.
- WAIT:
  - dmem_req=0; counter increments each cycle.
  - On rvalid: latch rdata, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES without rvalid: bus_err pulses, go to DONE with rf_we suppressed.
- DONE:
  - mwb_stall=0.
  - Writeback using latched data if the op was a load and there was no error. Stores never write.
  - Return to IDLE next edge.
- Load alignment: select byte/half by addr[1:0] / addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- Store byte enables from instruction_in[14:12]:
  - SB: be = 0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = 0011<<addr[1], wdata = {2{rs2[15:0]}}.
  - SW: be = 1111.
- Inputs are guaranteed stable while mwb_stall=1, because upstream is held.
- rvalid arriving in IDLE or REQ is ignored.
- Reset asserted mid-access: immediately returns to IDLE; any outstanding response after reset is ignored.
- Minimum load latency: req+gnt in cycle 0, rvalid in cycle 1, writeback in cycle 2. mwb_stall is high in cycles 0–1.

Test Plan:
- ALU op, WB_sel=00, ALU_result=0x0000_1234, rd=5, Reg_WE=1 → same cycle: rf_we=1, rf_waddr=5, rf_wdata=0x1234, mwb_stall=0. Repeat with rd=0 → rf_we=0.
- LB at addr 0x103, gnt same cycle, rvalid next cycle with rdata=0x80FF_FFFF → stall for 2 cycles, then rf_wdata=0xFFFF_FF80. Repeat as LBU → 0x0000_0080.
- SH at addr 0x102, rs2=0xABCD_1234, gnt delayed 3 cycles → dmem_req held 4 cycles, dmem_be=1100, dmem_wdata=0x1234_1234, dmem_we=1. After rvalid: rf_we=0.
- LW at addr 0x101 → misalign_err pulses for 1 cycle, dmem_req never asserts, rf_we=0, no stall.
- LW granted, no rvalid, TIMEOUT_CYCLES=4 → bus_err pulses after 4 WAIT cycles, rf_we=0, stall released, state back to IDLE.
- Drive rst low during WAIT → outputs 0 and state IDLE immediately. A late rvalid after reset release → ignored, no rf_we.

Source files
------------

// File: rtl/mwb_stage.sv
// Memory/writeback stage: load/store over req/gnt/rvalid, load alignment,
// writeback mux and register-file write port, with stall and error pulses.
`timescale 1ns/1ps
module mwb_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] IMME_result_in,
    input  logic [31:0] PC_in,
    input  logic [31:0] rs2_data_in,
    input  logic        Reg_WE_in,
    input  logic [1:0]  DMEM_sel_in,
    input  logic [2:0]  LOAD_sel_in,
    input  logic [1:0]  WB_sel_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        mwb_stall,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [31:0]     ld_q;
    logic            to_q;

    logic            is_load;
    logic            is_store;
    logic            mem_op;
    logic [1:0]      size;
    logic [1:0]      off;
    logic            misalign;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [3:0]      be_raw;
    logic [31:0]     wdata_raw;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [31:0]     ld_ext;
    logic [31:0]     wb_data;
    logic            wb_en;
    logic            drv;
    logic            unused;

    assign rd       = instruction_in[11:7];
    assign funct3   = instruction_in[14:12];
    assign off      = ALU_result_in[1:0];
    assign is_load  = (DMEM_sel_in == 2'b01);
    assign is_store = (DMEM_sel_in == 2'b10);
    assign mem_op   = is_load | is_store;
    assign wb_en    = Reg_WE_in & (rd != 5'd0);
    assign unused   = ^{instruction_in[31:15], instruction_in[6:0]};

    // size: 0 byte, 1 half, 2 word
    always_comb begin
        size = 2'd2;
        if (is_store) begin
            unique case (funct3)
                3'b000:  size = 2'd0;
                3'b001:  size = 2'd1;
                default: size = 2'd2;
            endcase
        end else begin
            unique case (LOAD_sel_in)
                3'b000, 3'b100: size = 2'd0;
                3'b001, 3'b101: size = 2'd1;
                default:        size = 2'd2;
            endcase
        end
    end

    assign misalign = mem_op &
                      (((size == 2'd1) & off[0]) |
                       ((size == 2'd2) & (off != 2'b00)));

    always_comb begin
        be_raw    = 4'b1111;
        wdata_raw = rs2_data_in;
        unique case (size)
            2'd0: begin
                be_raw    = 4'b0001 << off;
                wdata_raw = {4{rs2_data_in[7:0]}};
            end
            2'd1: begin
                be_raw    = 4'b0011 << {off[1], 1'b0};
                wdata_raw = {2{rs2_data_in[15:0]}};
            end
            default: begin
                be_raw    = 4'b1111;
                wdata_raw = rs2_data_in;
            end
        endcase
    end

    assign lane_b = 8'(ld_q >> {off, 3'b000});
    assign lane_h = 16'(ld_q >> {off[1], 4'b0000});

    always_comb begin
        ld_ext = ld_q;
        unique case (LOAD_sel_in)
            3'b000:  ld_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  ld_ext = {24'd0, lane_b};
            3'b101:  ld_ext = {16'd0, lane_h};
            default: ld_ext = ld_q;
        endcase
    end

    always_comb begin
        wb_data = ALU_result_in;
        unique case (WB_sel_in)
            2'b00: wb_data = ALU_result_in;
            2'b01: wb_data = ld_ext;
            2'b10: wb_data = PC_in + 32'd4;
            2'b11: wb_data = IMME_result_in;
        endcase
    end

    // Every output is forced low while reset is held.
    always_comb begin
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = 32'd0;
        dmem_be      = 4'd0;
        dmem_wdata   = 32'd0;
        rf_we        = 1'b0;
        rf_waddr     = 5'd0;
        rf_wdata     = 32'd0;
        mwb_stall    = 1'b0;
        misalign_err = 1'b0;
        bus_err      = 1'b0;
        drv          = 1'b0;
        if (rst) begin
            unique case (state)
                IDLE: begin
                    if (!mem_op) begin
                        rf_we    = wb_en;
                        rf_wdata = wb_data;
                    end else if (misalign) begin
                        misalign_err = 1'b1;
                    end else begin
                        drv       = 1'b1;
                        mwb_stall = 1'b1;
                    end
                end
                REQ: begin
                    drv       = 1'b1;
                    mwb_stall = 1'b1;
                end
                WAIT: begin
                    mwb_stall = 1'b1;
                end
                DONE: begin
                    rf_we    = is_load & ~to_q & wb_en;
                    rf_wdata = wb_data;
                    bus_err  = to_q;
                end
            endcase
            if (drv) begin
                dmem_req   = 1'b1;
                dmem_we    = is_store;
                dmem_addr  = {ALU_result_in[31:2], 2'b00};
                dmem_be    = be_raw;
                dmem_wdata = is_store ? wdata_raw : 32'd0;
            end
            if (rf_we) begin
                rf_waddr = rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            ld_q  <= 32'd0;
            to_q  <= 1'b0;
        end else begin
            to_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_op && !misalign) begin
                        cnt   <= '0;
                        state <= dmem_gnt ? WAIT : REQ;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        ld_q  <= dmem_rdata;
                        state <= DONE;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        to_q  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mwb_stage.sv
// Randomized bench for mwb_stage: drives ops and a bus responder, checks
// outputs against an arithmetic model of the stage.
`timescale 1ns/1ps
module tb_mwb_stage;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic [31:0] instruction_in;
    logic [31:0] ALU_result_in;
    logic [31:0] IMME_result_in;
    logic [31:0] PC_in;
    logic [31:0] rs2_data_in;
    logic        Reg_WE_in;
    logic [1:0]  DMEM_sel_in;
    logic [2:0]  LOAD_sel_in;
    logic [1:0]  WB_sel_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        mwb_stall;
    logic        misalign_err;
    logic        bus_err;

    int n_vec = 0;
    int n_err = 0;

    mwb_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .instruction_in (instruction_in),
        .ALU_result_in  (ALU_result_in),
        .IMME_result_in (IMME_result_in),
        .PC_in          (PC_in),
        .rs2_data_in    (rs2_data_in),
        .Reg_WE_in      (Reg_WE_in),
        .DMEM_sel_in    (DMEM_sel_in),
        .LOAD_sel_in    (LOAD_sel_in),
        .WB_sel_in      (WB_sel_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_gnt       (dmem_gnt),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .mwb_stall      (mwb_stall),
        .misalign_err   (misalign_err),
        .bus_err        (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [2:0] ls,
                                             input logic [1:0] o,
                                             input logic [31:0] w);
        logic [31:0] s;
        s = w >> (32'(o) * 8);
        case (ls)
            3'd0:    return {{24{s[7]}}, s[7:0]};
            3'd1:    return {{16{s[15]}}, s[15:0]};
            3'd4:    return {24'd0, s[7:0]};
            3'd5:    return {16'd0, s[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] wb_model(input logic [1:0] ws,
                                             input logic [31:0] alu,
                                             input logic [31:0] ld,
                                             input logic [31:0] pc,
                                             input logic [31:0] imm);
        case (ws)
            2'd0:    return alu;
            2'd1:    return ld;
            2'd2:    return pc + 4;
            default: return imm;
        endcase
    endfunction

    // rdly < 0 means the response never comes
    task automatic apply(input logic [1:0] dsel, input logic [2:0] lsel,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [4:0] rd,
                         input logic we, input logic [1:0] wbs,
                         input int gdly, input int rdly,
                         input logic [31:0] rdata);
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] imm;
        int nbytes;
        logic ld;
        logic st;
        logic mis;
        logic [31:0] ebe;
        logic [31:0] ewd;
        logic ewe;
        int nw;
        ins = $urandom;
        ins[14:12] = f3;
        ins[11:7] = rd;
        pc = $urandom;
        imm = $urandom;
        instruction_in = ins;
        ALU_result_in = addr;
        IMME_result_in = imm;
        PC_in = pc;
        rs2_data_in = rs2;
        Reg_WE_in = we;
        DMEM_sel_in = dsel;
        LOAD_sel_in = lsel;
        WB_sel_in = wbs;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata = $urandom;
        ld = (dsel == 2'd1);
        st = (dsel == 2'd2);
        if (st) nbytes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else nbytes = (lsel == 3'd0 || lsel == 3'd4) ? 1 :
                      (lsel == 3'd1 || lsel == 3'd5) ? 2 : 4;
        mis = (ld || st) && ((addr % nbytes) != 0);
        ebe = ((1 << nbytes) - 1) << (addr % 4);
        if (nbytes == 1) ewd = {24'd0, rs2[7:0]} * 32'h0101_0101;
        else if (nbytes == 2) ewd = {16'd0, rs2[15:0]} * 32'h0001_0001;
        else ewd = rs2;
        if (!(ld || st)) begin
            @(negedge clk);
            ewe = we && (rd != 0);
            chk("alu_we", rf_we, ewe);
            if (ewe) begin
                chk("alu_waddr", rf_waddr, rd);
                chk("alu_wdata", rf_wdata, wb_model(wbs, addr, 0, pc, imm));
            end
            chk("alu_stall", mwb_stall, 0);
            chk("alu_req", dmem_req, 0);
            @(posedge clk); #1;
        end else if (mis) begin
            @(negedge clk);
            chk("mis_err", misalign_err, 1);
            chk("mis_req", dmem_req, 0);
            chk("mis_stall", mwb_stall, 0);
            chk("mis_we", rf_we, 0);
            @(posedge clk); #1;
            DMEM_sel_in = 2'd0;
            Reg_WE_in = 1'b0;
            @(negedge clk);
            chk("mis_pulse", misalign_err, 0);
            @(posedge clk); #1;
        end else begin
            for (int i = 0; i <= gdly; i++) begin
                dmem_gnt = (i == gdly);
                dmem_rvalid = $urandom_range(0, 1);
                dmem_rdata = $urandom;
                @(negedge clk);
                chk("req", dmem_req, 1);
                chk("req_stall", mwb_stall, 1);
                chk("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
                chk("req_we", dmem_we, st);
                if (st) begin
                    chk("req_be", dmem_be, ebe);
                    chk("req_wdata", dmem_wdata, ewd);
                end
                @(posedge clk); #1;
            end
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
            nw = (rdly < 0) ? TO : rdly;
            for (int j = 0; j < nw; j++) begin
                @(negedge clk);
                chk("wait_req", dmem_req, 0);
                chk("wait_stall", mwb_stall, 1);
                chk("wait_berr", bus_err, 0);
                @(posedge clk); #1;
            end
            if (rdly >= 0) begin
                dmem_rvalid = 1'b1;
                dmem_rdata = rdata;
                @(negedge clk);
                chk("rv_stall", mwb_stall, 1);
                @(posedge clk); #1;
                dmem_rvalid = 1'b0;
                dmem_rdata = $urandom;
            end
            @(negedge clk);
            ewe = ld && (rdly >= 0) && we && (rd != 0);
            chk("done_stall", mwb_stall, 0);
            chk("done_berr", bus_err, rdly < 0);
            chk("done_we", rf_we, ewe);
            if (ewe) begin
                chk("done_waddr", rf_waddr, rd);
                chk("done_wdata", rf_wdata,
                    wb_model(wbs, addr, ld_model(lsel, addr[1:0], rdata),
                             pc, imm));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [1:0] ds;
        logic [1:0] ws;
        int rdl;
        rst = 1'b0;
        instruction_in = 32'h0000_0283;
        ALU_result_in = 32'h0000_0200;
        IMME_result_in = 32'd0;
        PC_in = 32'd0;
        rs2_data_in = 32'd0;
        Reg_WE_in = 1'b1;
        DMEM_sel_in = 2'd1;
        LOAD_sel_in = 3'd2;
        WB_sel_in = 2'd1;
        dmem_gnt = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        #12;
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", mwb_stall, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_errs", {misalign_err, bus_err}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;

        apply(2'd0, 3'd2, 3'd0, 32'h0000_1234, 0, 5'd5, 1, 2'd0, 0, 0, 0);
        apply(2'd0, 3'd2, 3'd0, 32'h0000_1234, 0, 5'd0, 1, 2'd0, 0, 0, 0);
        apply(2'd0, 3'd2, 3'd0, 32'h0000_1234, 0, 5'd7, 1, 2'd2, 0, 0, 0);
        apply(2'd1, 3'd0, 3'd0, 32'h0000_0103, 0, 5'd9, 1, 2'd1, 0, 0,
              32'h80FF_FFFF);
        apply(2'd1, 3'd4, 3'd0, 32'h0000_0103, 0, 5'd9, 1, 2'd1, 0, 0,
              32'h80FF_FFFF);
        apply(2'd2, 3'd0, 3'd1, 32'h0000_0102, 32'hABCD_1234, 5'd4, 1,
              2'd0, 3, 0, 0);
        apply(2'd1, 3'd2, 3'd0, 32'h0000_0101, 0, 5'd3, 1, 2'd1, 0, 0, 0);
        apply(2'd1, 3'd2, 3'd0, 32'h0000_0100, 0, 5'd3, 1, 2'd1, 0, -1, 0);
        apply(2'd1, 3'd1, 3'd0, 32'h0000_0102, 0, 5'd6, 1, 2'd1, 1, TO - 1,
              32'h8001_7FFF);

        // reset in the middle of a load, then a stray response
        DMEM_sel_in = 2'd1;
        LOAD_sel_in = 3'd2;
        ALU_result_in = 32'h0000_0200;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(negedge clk);
        chk("wait_pre_rst", mwb_stall, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", mwb_stall, 0);
        chk("mid_rst_req", dmem_req, 0);
        chk("mid_rst_we", rf_we, 0);
        DMEM_sel_in = 2'd0;
        Reg_WE_in = 1'b1;
        instruction_in = 32'h0000_0183;
        WB_sel_in = 2'd1;
        @(posedge clk); #1;
        rst = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("late_rv_stall", mwb_stall, 0);
        chk("late_rv_req", dmem_req, 0);
        chk("late_rv_data", rf_wdata, 0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rv_data2", rf_wdata, 0);
        @(posedge clk); #1;

        for (int k = 0; k < 300; k++) begin
            ds = 2'($urandom_range(0, 3));
            ws = 2'($urandom_range(0, 3));
            if (ds == 2'd0 || ds == 2'd3) begin
                while (ws == 2'd1) ws = 2'($urandom_range(0, 3));
            end
            rdl = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, TO - 1);
            apply(ds, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  $urandom, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), ws, $urandom_range(0, 3), rdl,
                  $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
